// File: rtl/priority_arbiter.sv
// priority_arbiter: 8-way (parameterised) arbiter with a two-state FSM.
// The highest requesting index wins by default. The grant is held until the
// winner signals done, drops its request, or the hold timeout fires.
// Optional feature macro: ARB_ROUND_ROBIN_EN (rotating priority pointer).
//
// Handshake: a requester raises req[i] and keeps it high while it wants the
// resource. Once gnt[i] is seen, the owner keeps req[i] high for as long as it
// uses the resource. It ends ownership either by pulsing done[i] for one cycle
// or by dropping req[i]; both take effect on the next rising edge. done bits of
// non-granted requesters carry no meaning, and other requests never preempt.
module priority_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout,
  output logic             state_dbg
);

  localparam int CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     gnt_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             valid_nxt;
  logic             timeout_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic [IDX_W-1:0] win_idx;
  logic             owner_release;
  logic             forced_release;

  assign state_dbg = state;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr, ptr_nxt;

  // Round-robin search: walk downward from ptr-1 with wrap; nearest hit wins.
  always_comb begin
    win_idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[IDX_W'((int'(ptr) + N - k) % N)]) win_idx = IDX_W'((int'(ptr) + N - k) % N);
    end
  end

  // Rotation pointer remembers the most recent winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= IDX_W'(N - 1);
    else        ptr <= ptr_nxt;
  end
`else
  // Fixed priority: the highest set request bit wins.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) win_idx = IDX_W'(i);
    end
  end
`endif

  // Release conditions seen while a grant is active.
  always_comb begin
    owner_release  = done[gnt_idx] || !req[gnt_idx];
    forced_release = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  end

  // Next-state and registered-output logic for the IDLE/GRANT FSM.
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    idx_nxt     = gnt_idx;
    valid_nxt   = gnt_valid;
    timeout_nxt = 1'b0;
    cnt_nxt     = hold_cnt;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_nxt     = ptr;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          gnt_nxt   = N'(1) << win_idx;
          idx_nxt   = win_idx;
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_nxt   = win_idx;
`endif
        end
      end
      GRANT: begin
        if (owner_release || forced_release) begin
          // Owner-initiated release wins over a coincident timeout.
          state_nxt   = IDLE;
          gnt_nxt     = '0;
          idx_nxt     = '0;
          valid_nxt   = 1'b0;
          timeout_nxt = !owner_release;
        end else if (hold_cnt != '1) begin
          cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
      timeout   <= timeout_nxt;
      hold_cnt  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed testbench for priority_arbiter (N=8, MAX_HOLD=16).
module tb_priority_arbiter;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] gnt;
  logic [2:0]   gnt_idx;
  logic         gnt_valid;
  logic         timeout;
  logic         state_dbg;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  priority_arbiter #(.N(N), .IDX_W(3), .MAX_HOLD(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid),
    .timeout(timeout), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // advance one rising edge, then settle before sampling/driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = '0;
    #12;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [2:0] e;
    rst_n = 1'b0;
    req   = '0;
    done  = '0;
    #2;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_valid", 32'(gnt_valid), 0);
    do_reset();

    // reset / idle
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_gnt", 32'(gnt), 0);
      check("idle_valid", 32'(gnt_valid), 0);
      check("idle_timeout", 32'(timeout), 0);
      check("idle_idx", 32'(gnt_idx), 0);
    end

    // priority selection and normal release
    req = 8'b0011_0101;
    step();
    check("fp_gnt", 32'(gnt), 32'h20);
    check("fp_idx", 32'(gnt_idx), 5);
    check("fp_valid", 32'(gnt_valid), 1);
    check("fp_state", 32'(state_dbg), 1);
    done = 8'h20;
    step();
    check("rel_gnt", 32'(gnt), 0);
    check("rel_valid", 32'(gnt_valid), 0);
    check("rel_timeout", 32'(timeout), 0);
    done = '0;
    req  = 8'b0001_0101;
    step();
    check("fp2_idx", 32'(gnt_idx), 4);
    check("fp2_gnt", 32'(gnt), 32'h10);
    req = '0;
    step();
    check("impl0_valid", 32'(gnt_valid), 0);
    check("impl0_timeout", 32'(timeout), 0);

    // foreign done / higher request must not disturb the grant
    req = 8'h04;
    step();
    check("pre_idx", 32'(gnt_idx), 2);
    req  = 8'h84;
    done = 8'h40;
    step();
    check("pre_hold_idx", 32'(gnt_idx), 2);
    check("pre_hold_valid", 32'(gnt_valid), 1);
    step();
    check("pre_hold2_gnt", 32'(gnt), 32'h04);
    done = 8'h04;
    step();
    check("pre_rel_valid", 32'(gnt_valid), 0);
    req  = '0;
    done = '0;
    step();

    // hold timeout
    req = 8'h08;
    step();
    for (int i = 0; i < 16; i++) begin
      check("to_idx", 32'(gnt_idx), 3);
      check("to_valid", 32'(gnt_valid), 1);
      check("to_pulse_early", 32'(timeout), 0);
      step();
    end
    check("to_drop_valid", 32'(gnt_valid), 0);
    check("to_drop_gnt", 32'(gnt), 0);
    check("to_pulse", 32'(timeout), 1);
    step();
    check("to_pulse_end", 32'(timeout), 0);
    check("to_regrant_idx", 32'(gnt_idx), 3);
    for (int i = 0; i < 15; i++) step();
    check("to2_valid_late", 32'(gnt_valid), 1);
    done = 8'h08;
    step();
    check("to2_valid", 32'(gnt_valid), 0);
    check("to2_no_timeout", 32'(timeout), 0);
    done = '0;
    req  = '0;
    step();
    check("to2_after", 32'(timeout), 0);

    // implicit release
    req = 8'h02;
    step();
    check("imp_idx", 32'(gnt_idx), 1);
    step();
    check("imp_hold", 32'(gnt), 32'h02);
    req = '0;
    step();
    check("imp_valid", 32'(gnt_valid), 0);
    check("imp_timeout", 32'(timeout), 0);

    // asynchronous reset mid-grant
    req = 8'h02;
    step();
    check("ar_valid_pre", 32'(gnt_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_gnt", 32'(gnt), 0);
    check("ar_valid", 32'(gnt_valid), 0);
    check("ar_idx", 32'(gnt_idx), 0);
    #1;
    req   = '0;
    rst_n = 1'b1;
    step();
    check("ar_idle", 32'(gnt_valid), 0);
    req = 8'h40;
    step();
    check("ar_first_idx", 32'(gnt_idx), 6);
    req = '0;
    step();

    // full request vector, one grant per done pulse
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    exp_q = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
`else
    exp_q = '{3'd7, 3'd7, 3'd7, 3'd7};
`endif
    req = 8'hFF;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step();
      check("seq_idx", 32'(gnt_idx), 32'(e));
      check("seq_valid", 32'(gnt_valid), 1);
      done = 8'h01 << e;
      step();
      check("seq_rel", 32'(gnt_valid), 0);
      done = '0;
    end
    req = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
